// File: rtl/msg_scheduler.sv
// msg_scheduler: arbitrates status/event/banner sources onto the 4-char message field.
// Optional blinking of event messages is built only when MSG_SCHED_BLINK_EN is defined.
module msg_scheduler #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int BLINK_CYCLES  = 12_500_000,
  parameter int SCROLL_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] status_chars,
  input  logic        evt_valid,
  input  logic [23:0] evt_chars,
  input  logic        evt_blink,
  output logic        evt_ready,
  input  logic        banner_start,
  input  logic [95:0] banner_chars,
  input  logic [4:0]  banner_len,
  output logic [23:0] msg_chars,
  output logic        busy
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = SCROLL_CYCLES > 1 ? $clog2(SCROLL_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EVENT, SCROLL} state_t;
  state_t          state_q;
  logic [23:0]     msg_q, evt_q;
  logic [HW-1:0]   hold_q;
  logic [SW-1:0]   scr_q;
  logic [4:0]      step_q, len_q;
  logic [5:0]      ban_q [16];
  logic            accept;
  assign accept    = evt_valid && state_q != EVENT;
  assign evt_ready = reset || state_q != EVENT;
  assign busy      = state_q != IDLE;
  assign msg_chars = msg_q;
`ifdef MSG_SCHED_BLINK_EN
  localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] blk_q;
  logic          ph_q, blink_q, blk_end;
  assign blk_end = blk_q == '0;
`else
  logic unused_blink;
  assign unused_blink = evt_blink ^ (BLINK_CYCLES > 0);
`endif
  // Window at step p: hex k shows char[p-1-k], blank when outside the banner.
  function automatic logic [23:0] win(input logic [4:0] p);
    logic [23:0] w;
    logic [4:0]  i;
    w = '1;
    for (int k = 0; k < 4; k++) begin
      i = p - 5'(k + 1);
      w[6*k +: 6] = (p > 5'(k) && i < len_q) ? ban_q[i[3:0]] : 6'h3F;
    end
    return w;
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '1;
      evt_q   <= '1;
      hold_q  <= '0;
      scr_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
`ifdef MSG_SCHED_BLINK_EN
      blk_q   <= '0;
      ph_q    <= 1'b0;
      blink_q <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= EVENT;
      evt_q   <= evt_chars;
      msg_q   <= evt_chars;
      hold_q  <= HW'(HOLD_CYCLES - 1);
      scr_q   <= '0;
      step_q  <= '0;
`ifdef MSG_SCHED_BLINK_EN
      blk_q   <= BW'(BLINK_CYCLES - 1);
      ph_q    <= 1'b1;
      blink_q <= evt_blink;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          msg_q <= status_chars;
          if (banner_start && banner_len != 5'd0) begin
            state_q <= SCROLL;
            len_q   <= banner_len > 5'd16 ? 5'd16 : banner_len;
            for (int i = 0; i < 16; i++) ban_q[i] <= banner_chars[6*i +: 6];
            step_q  <= 5'd1;
            scr_q   <= SW'(SCROLL_CYCLES - 1);
            msg_q   <= {18'h3FFFF, banner_chars[5:0]};
          end
        end
        EVENT: begin
          if (hold_q == '0) begin
            state_q <= IDLE;
            msg_q   <= status_chars;
          end else begin
            hold_q <= hold_q - 1'b1;
`ifdef MSG_SCHED_BLINK_EN
            blk_q <= blk_end ? BW'(BLINK_CYCLES - 1) : blk_q - 1'b1;
            ph_q  <= ph_q ^ blk_end;
            msg_q <= (!blink_q || (ph_q ^ blk_end)) ? evt_q : '1;
`else
            msg_q <= evt_q;
`endif
          end
        end
        SCROLL: begin
          if (scr_q != '0) scr_q <= scr_q - 1'b1;
          else if (step_q == len_q + 5'd3) begin
            state_q <= IDLE;
            step_q  <= '0;
            msg_q   <= status_chars;
          end else begin
            step_q <= step_q + 5'd1;
            scr_q  <= SW'(SCROLL_CYCLES - 1);
            msg_q  <= win(step_q + 5'd1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msg_scheduler.sv
// tb_msg_scheduler: directed checks of msg_scheduler with short timer parameters.
module tb_msg_scheduler;
  logic        clk = 1'b0;
  logic        reset, evt_valid, evt_blink, banner_start;
  logic [23:0] status_chars, evt_chars, msg_chars;
  logic [95:0] banner_chars;
  logic [4:0]  banner_len;
  logic        evt_ready, busy;
  int          vec = 0, miss = 0;
  localparam logic [23:0] PLAY  = {6'h19, 6'h15, 6'h0A, 6'h22};
  localparam logic [23:0] WIN   = {6'h3F, 6'h20, 6'h12, 6'h17};
  localparam logic [23:0] LOSE  = {6'h15, 6'h18, 6'h1C, 6'h0E};
  localparam logic [23:0] TIE   = {6'h3F, 6'h1D, 6'h12, 6'h0E};
  localparam logic [23:0] BLANK = 24'hFFFFFF;
  logic [23:0] hello [8];
  logic [23:0] lose_exp [8];
  msg_scheduler #(.HOLD_CYCLES(8), .BLINK_CYCLES(2), .SCROLL_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .status_chars(status_chars), .evt_valid(evt_valid),
    .evt_chars(evt_chars), .evt_blink(evt_blink), .evt_ready(evt_ready),
    .banner_start(banner_start), .banner_chars(banner_chars), .banner_len(banner_len),
    .msg_chars(msg_chars), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    hello[0] = {6'h3F, 6'h3F, 6'h3F, 6'h11};
    hello[1] = {6'h3F, 6'h3F, 6'h11, 6'h0E};
    hello[2] = {6'h3F, 6'h11, 6'h0E, 6'h15};
    hello[3] = {6'h11, 6'h0E, 6'h15, 6'h15};
    hello[4] = {6'h0E, 6'h15, 6'h15, 6'h18};
    hello[5] = {6'h15, 6'h15, 6'h18, 6'h3F};
    hello[6] = {6'h15, 6'h18, 6'h3F, 6'h3F};
    hello[7] = {6'h18, 6'h3F, 6'h3F, 6'h3F};
`ifdef MSG_SCHED_BLINK_EN
    lose_exp = '{LOSE, LOSE, BLANK, BLANK, LOSE, LOSE, BLANK, BLANK};
`else
    lose_exp = '{LOSE, LOSE, LOSE, LOSE, LOSE, LOSE, LOSE, LOSE};
`endif
    reset = 1'b1; evt_valid = 1'b0; evt_blink = 1'b0; banner_start = 1'b0;
    status_chars = PLAY; evt_chars = WIN; banner_len = 5'd0;
    banner_chars = {66'h0, 6'h18, 6'h15, 6'h15, 6'h0E, 6'h11};
    banner_chars[95:30] = {11{6'h05}};
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_msg", msg_chars, BLANK);
      chk("reset_ready", 24'(evt_ready), 24'd1);
      chk("reset_busy", 24'(busy), 24'd0);
      evt_valid = (i == 1);
    end
    reset = 1'b0; evt_valid = 1'b0;
    cyc();
    chk("post_reset_msg", msg_chars, PLAY);
    chk("post_reset_busy", 24'(busy), 24'd0);
    status_chars = TIE;
    cyc();
    chk("status_follow", msg_chars, TIE);
    status_chars = PLAY;
    cyc();
    chk("status_back", msg_chars, PLAY);
    evt_valid = 1'b1; evt_chars = WIN; evt_blink = 1'b0;
    cyc();
    evt_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("win_msg", msg_chars, WIN);
      chk("win_ready", 24'(evt_ready), 24'd0);
      chk("win_busy", 24'(busy), 24'd1);
      if (i == 7) begin evt_valid = 1'b1; evt_chars = LOSE; evt_blink = 1'b1; end
      cyc();
    end
    chk("win_end_msg", msg_chars, PLAY);
    chk("win_end_busy", 24'(busy), 24'd0);
    chk("win_end_ready", 24'(evt_ready), 24'd1);
    cyc();
    evt_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lose_msg", msg_chars, lose_exp[i]);
      chk("lose_busy", 24'(busy), 24'd1);
      cyc();
    end
    chk("lose_end_msg", msg_chars, PLAY);
    evt_blink = 1'b0;
    banner_start = 1'b1; banner_len = 5'd0;
    cyc();
    banner_start = 1'b0;
    chk("len0_msg", msg_chars, PLAY);
    chk("len0_busy", 24'(busy), 24'd0);
    banner_start = 1'b1; banner_len = 5'd5;
    cyc();
    banner_start = 1'b0;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("hello_step%0d", s + 1), msg_chars, hello[s]);
        chk("hello_busy", 24'(busy), 24'd1);
        cyc();
      end
    chk("hello_end_msg", msg_chars, PLAY);
    chk("hello_end_busy", 24'(busy), 24'd0);
    banner_start = 1'b1;
    cyc();
    banner_start = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    chk("preempt_step3", msg_chars, hello[2]);
    evt_valid = 1'b1; evt_chars = WIN;
    cyc();
    evt_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("preempt_win", msg_chars, WIN);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      chk("no_resume_msg", msg_chars, PLAY);
      chk("no_resume_busy", 24'(busy), 24'd0);
      cyc();
    end
    evt_valid = 1'b1; evt_chars = TIE; banner_start = 1'b1;
    cyc();
    evt_valid = 1'b0; banner_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tie_msg", msg_chars, TIE);
      cyc();
    end
    reset = 1'b1;
    cyc();
    chk("midreset_msg", msg_chars, BLANK);
    chk("midreset_busy", 24'(busy), 24'd0);
    chk("midreset_ready", 24'(evt_ready), 24'd1);
    reset = 1'b0;
    cyc();
    chk("after_reset_msg", msg_chars, PLAY);
    chk("after_reset_ready", 24'(evt_ready), 24'd1);
    cyc();
    chk("tie_dropped_banner", msg_chars, PLAY);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
